reg_bus_fabric: RTL and testbench

Parametrised register-bus interconnect between the frame address decoder (bus master) and N register peripherals (clock handler, UART, channel processor, color processor, and future slaves). It replaces the fixed OR-gate response combining with a registered, transaction-tracked fabric. The fabric broadcasts one request at a time and collects the slave responses. It detects a silent bus (timeout) and bus contention (more than one slave acknowledging), and reports both as faults to the 7-segment/debug path.

---
 rtl/reg_bus_fabric.sv | 186 ++++++++++++++++++
 tb/tb_reg_bus_fabric.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_fabric.sv
// reg_bus_fabric
// Register-bus interconnect between one master (the frame address decoder) and
// N_SLV register slaves. One request at a time is broadcast to all slaves. The
// slave responses are collected and returned to the master as a single
// registered response. A silent bus (timeout) and bus contention (more than one
// slave acking in the same cycle) are reported as faults.
//
// Ports
//   clk, rst       system clock; synchronous active-high reset
//   m_address      master request address
//   m_data         master write data
//   m_valid        master request, held until m_ack and then dropped
//   m_ack          one-cycle response pulse to the master
//   m_rdata        read data, meaningful only while m_rdata_valid=1
//   m_rdata_valid  one-cycle pulse, coincident with m_ack
//   m_fault        one-cycle pulse, coincident with m_ack on a faulted transfer
//   fault_code     last fault: 00 none, 01 timeout, 10 multi-ack
//   fault_count    saturating count of faulted transactions
//   last_slave     lowest acking slave index of the last acked transaction
//   s_address      registered broadcast address
//   s_data         registered broadcast data
//   s_valid        broadcast request strobe
//   s_ack          per-slave acknowledge
//   s_rdata        per-slave read data, slave i at [i*DW +: DW]
//   s_rdata_valid  per-slave read data valid
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | bus quiet, waiting for m_valid
// ST_WAIT  | s_valid high, waiting for any s_ack or the timeout
// ST_RESP  | m_ack (and possibly m_rdata_valid / m_fault) high for one cycle
// ST_DRAIN | waiting for the master to drop m_valid

module reg_bus_fabric #(
    parameter int N_SLV   = 4,
    parameter int AW      = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15,
    localparam int SW     = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       m_address,
    input  logic [DW-1:0]       m_data,
    input  logic                m_valid,
    output logic                m_ack,
    output logic [DW-1:0]       m_rdata,
    output logic                m_rdata_valid,
    output logic                m_fault,
    output logic [1:0]          fault_code,
    output logic [7:0]          fault_count,
    output logic [SW-1:0]       last_slave,
    output logic [AW-1:0]       s_address,
    output logic [DW-1:0]       s_data,
    output logic                s_valid,
    input  logic [N_SLV-1:0]    s_ack,
    input  logic [N_SLV*DW-1:0] s_rdata,
    input  logic [N_SLV-1:0]    s_rdata_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_TMO   = 2'b01;
    localparam logic [1:0] FC_MULTI = 2'b10;

    state_t         state;
    state_t         state_nxt;

    // Down-counter loaded on request latch; terminal count 0 in ST_WAIT means
    // s_valid has been high for TIMEOUT cycles.
    logic [7:0]     tmr;

    logic           any_ack;
    logic           multi_ack;
    logic           tmo_hit;
    logic           ack_take;
    logic           tmo_take;
    logic [DW-1:0]  rd_or;
    logic [SW-1:0]  low_idx;

    always_comb begin
        rd_or   = '0;
        low_idx = '0;
        // Walking downward leaves the lowest acking index in low_idx.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (s_rdata_valid[i]) begin
                rd_or = rd_or | s_rdata[i*DW +: DW];
            end
            if (s_ack[i]) begin
                low_idx = SW'(i);
            end
        end
    end

    assign any_ack   = |s_ack;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_ack = |(s_ack & (s_ack - N_SLV'(1)));
    assign tmo_hit   = (tmr == 8'd0);
    assign ack_take  = (state == ST_WAIT) && any_ack;
    assign tmo_take  = (state == ST_WAIT) && !any_ack && tmo_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (m_valid) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (any_ack || tmo_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!m_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            tmr           <= 8'd0;
            s_valid       <= 1'b0;
            s_address     <= '0;
            s_data        <= '0;
            m_ack         <= 1'b0;
            m_rdata       <= '0;
            m_rdata_valid <= 1'b0;
            m_fault       <= 1'b0;
            fault_code    <= FC_NONE;
            fault_count   <= 8'd0;
            last_slave    <= '0;
        end else begin
            state         <= state_nxt;
            // Strobes are registered from the next state so no s_* input
            // reaches an m_* output combinationally.
            s_valid       <= (state_nxt == ST_WAIT);
            m_ack         <= (state_nxt == ST_RESP);
            m_rdata_valid <= 1'b0;
            m_fault       <= 1'b0;

            if ((state == ST_IDLE) && m_valid) begin
                s_address <= m_address;
                s_data    <= m_data;
                tmr       <= 8'(TIMEOUT - 1);
            end else if ((state == ST_WAIT) && !tmo_hit) begin
                tmr <= tmr - 8'd1;
            end

            if (ack_take) begin
                m_rdata       <= rd_or;
                m_rdata_valid <= |s_rdata_valid;
                m_fault       <= multi_ack;
                fault_code    <= multi_ack ? FC_MULTI : FC_NONE;
                last_slave    <= low_idx;
                if (multi_ack && (fault_count != 8'hFF)) begin
                    fault_count <= fault_count + 8'd1;
                end
            end else if (tmo_take) begin
                // m_rdata and last_slave keep their previous values on timeout.
                m_fault    <= 1'b1;
                fault_code <= FC_TMO;
                if (fault_count != 8'hFF) begin
                    fault_count <= fault_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_fabric.sv
// tb_reg_bus_fabric
// Bench for reg_bus_fabric with the default parameters (4 slaves, 4-bit
// address/data, TIMEOUT=15). A driver task plays master and slaves for one
// transaction and pushes the expected response to a scoreboard queue; a
// monitor pops it when m_ack appears and compares, then checks the status
// registers on the following cycle.

module tb_reg_bus_fabric;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int DW  = 4;
    localparam int TMO = 15;
    localparam int SW  = $clog2(N);

    typedef struct {
        logic [DW-1:0] rdata;
        logic          rvalid;
        logic          fault;
        logic [1:0]    code;
        logic [7:0]    cnt;
        logic [SW-1:0] last;
        int            cyc;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     m_address;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ack;
    logic [DW-1:0]     m_rdata;
    logic              m_rdata_valid;
    logic              m_fault;
    logic [1:0]        fault_code;
    logic [7:0]        fault_count;
    logic [SW-1:0]     last_slave;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_data;
    logic              s_valid;
    logic [N-1:0]      s_ack;
    logic [N*DW-1:0]   s_rdata;
    logic [N-1:0]      s_rdata_valid;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_cnt = 0;

    exp_t sb[$];
    exp_t cur;
    bit   pend = 1'b0;

    // running model of the status registers
    logic [1:0]    exp_code = 2'b00;
    logic [7:0]    exp_cnt  = 8'd0;
    logic [SW-1:0] exp_last = '0;

    reg_bus_fabric #(
        .N_SLV   (N),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m_address     (m_address),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ack         (m_ack),
        .m_rdata       (m_rdata),
        .m_rdata_valid (m_rdata_valid),
        .m_fault       (m_fault),
        .fault_code    (fault_code),
        .fault_count   (fault_count),
        .last_slave    (last_slave),
        .s_address     (s_address),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ack         (s_ack),
        .s_rdata       (s_rdata),
        .s_rdata_valid (s_rdata_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (pend) begin
            chk("fault_code", 32'(fault_code), 32'(cur.code));
            chk("fault_count", 32'(fault_count), 32'(cur.cnt));
            chk("last_slave", 32'(last_slave), 32'(cur.last));
            pend = 1'b0;
        end
        if (m_ack) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'(m_ack), 32'd0);
            end else begin
                cur = sb.pop_front();
                chk("ack_cycle", cyc_cnt, cur.cyc);
                chk("m_rdata_valid", 32'(m_rdata_valid), 32'(cur.rvalid));
                chk("m_fault", 32'(m_fault), 32'(cur.fault));
                if (cur.rvalid) begin
                    chk("m_rdata", 32'(m_rdata), 32'(cur.rdata));
                end
                pend = 1'b1;
            end
        end else begin
            chk("stray_pulse", 32'({m_rdata_valid, m_fault}), 32'd0);
        end
    end

    // One master transaction. ack_at is the WAIT cycle in which the slaves
    // drive ackv; outside 1..TMO (or with ackv=0) the transfer times out.
    // hold is the number of cycles m_valid stays high after m_ack.
    task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int ack_at, input logic [N-1:0] ackv,
                           input logic [N-1:0] rvv, input logic [N*DW-1:0] rbus,
                           input int hold);
        exp_t e;
        int   rk;
        bit   got_ack;
        got_ack  = (ack_at >= 1) && (ack_at <= TMO) && (ackv != '0);
        rk       = got_ack ? ack_at : TMO;
        e.rdata  = '0;
        e.rvalid = 1'b0;
        e.fault  = 1'b0;
        if (got_ack) begin
            for (int i = 0; i < N; i++) begin
                if (rvv[i]) e.rdata = e.rdata | rbus[i*DW +: DW];
            end
            e.rvalid = |rvv;
            e.fault  = ($countones(ackv) > 1);
            exp_code = e.fault ? 2'b10 : 2'b00;
            for (int i = N - 1; i >= 0; i--) begin
                if (ackv[i]) exp_last = SW'(i);
            end
        end else begin
            e.fault  = 1'b1;
            exp_code = 2'b01;
        end
        if (e.fault && (exp_cnt != 8'hFF)) exp_cnt = exp_cnt + 8'd1;
        e.code = exp_code;
        e.cnt  = exp_cnt;
        e.last = exp_last;

        @(negedge clk);
        m_address = addr;
        m_data    = data;
        m_valid   = 1'b1;
        e.cyc     = cyc_cnt + rk + 1;
        sb.push_back(e);

        for (int n = 1; n <= rk + 1; n++) begin
            @(negedge clk);
            chk("s_valid", 32'(s_valid), 32'(n <= rk));
            if (n == 1) begin
                chk("s_address", 32'(s_address), 32'(addr));
                chk("s_data", 32'(s_data), 32'(data));
            end
            if (got_ack && (n == rk)) begin
                s_ack         = ackv;
                s_rdata_valid = rvv;
                s_rdata       = rbus;
            end else begin
                s_ack         = '0;
                s_rdata_valid = '0;
                s_rdata       = (N*DW)'($urandom);
            end
            if ((n == rk + 1) && (hold == 0)) m_valid = 1'b0;
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("drain_s_valid", 32'(s_valid), 32'd0);
            end
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        m_address     = '0;
        m_data        = '0;
        m_valid       = 1'b0;
        s_ack         = '0;
        s_rdata       = '0;
        s_rdata_valid = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m_ack", 32'(m_ack), 32'd0);
        chk("rst_fault_count", 32'(fault_count), 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        chk("rst_last_slave", 32'(last_slave), 32'd0);
        chk("rst_m_rdata", 32'(m_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // write to slave 2, ack in cycle 1
        run_txn(4'h5, 4'hA, 1, 4'b0100, 4'b0000, 16'h0000, 0);
        // read from slave 1 at cycle 3; other slices carry junk without valid
        run_txn(4'h2, 4'h0, 3, 4'b0010, 4'b0010, 16'hFF7F, 0);
        // silent bus
        run_txn(4'h9, 4'h3, 0, 4'b0000, 4'b0000, 16'h0000, 0);
        // ack exactly on the last WAIT cycle wins over the timeout
        run_txn(4'h1, 4'h4, TMO, 4'b0001, 4'b0001, 16'h000C, 0);
        // contention: slaves 0 and 3
        run_txn(4'hC, 4'h0, 2, 4'b1001, 4'b1001, 16'h8001, 0);
        // request held 10 cycles past m_ack
        run_txn(4'h7, 4'h2, 2, 4'b0100, 4'b0100, 16'h0B00, 10);

        for (int t = 0; t < 12; t++) begin
            run_txn(AW'($urandom), DW'($urandom), int'($urandom_range(1, TMO + 2)),
                    N'($urandom), N'($urandom), (N*DW)'($urandom), int'($urandom_range(0, 2)));
        end

        for (int t = 0; t < 300; t++) begin
            run_txn(AW'(t), DW'(t), 0, 4'b0000, 4'b0000, 16'h0000, 0);
        end
        chk("fault_count_sat", 32'(fault_count), 32'd255);

        // reset during the third WAIT cycle
        @(negedge clk);
        m_address = 4'h3;
        m_data    = 4'h6;
        m_valid   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_valid", 32'(s_valid), 32'd0);
        chk("midrst_fault_count", 32'(fault_count), 32'd0);
        chk("midrst_fault_code", 32'(fault_code), 32'd0);
        chk("midrst_s_address", 32'(s_address), 32'd0);
        chk("midrst_last_slave", 32'(last_slave), 32'd0);
        rst      = 1'b0;
        m_valid  = 1'b0;
        s_ack    = 4'b1111;
        exp_cnt  = 8'd0;
        exp_code = 2'b00;
        exp_last = '0;
        repeat (4) begin
            @(negedge clk);
            chk("stale_ack_s_valid", 32'(s_valid), 32'd0);
        end
        s_ack = '0;
        @(negedge clk);

        // fabric still works after the reset
        run_txn(4'hE, 4'h5, 4, 4'b1000, 4'b1000, 16'hD000, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
